// File: rtl/acc_cu_pkg.sv
// acc_cu_pkg: shared state, opcode, ALU, selData and cond encodings for the accumulator control unit
package acc_cu_pkg;
    localparam int OPW = 3;
    localparam int ACW = 2;
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_IF   = 4'd1,
        S_ID   = 4'd2,
        S_MEM  = 4'd3,
        S_EX   = 4'd4,
        S_WB   = 4'd5,
        S_ST   = 4'd6,
        S_BR   = 4'd7,
        S_HALT = 4'd8
    } state_t;
    localparam logic [OPW-1:0] OP_LDA = 3'b000;
    localparam logic [OPW-1:0] OP_STA = 3'b001;
    localparam logic [OPW-1:0] OP_ADD = 3'b010;
    localparam logic [OPW-1:0] OP_SUB = 3'b011;
    localparam logic [OPW-1:0] OP_AND = 3'b100;
    localparam logic [OPW-1:0] OP_OR  = 3'b101;
    localparam logic [OPW-1:0] OP_JCC = 3'b110;
    localparam logic [OPW-1:0] OP_HLT = 3'b111;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [1:0] SD_DATA = 2'b00;
    localparam logic [1:0] SD_ALU  = 2'b01;
    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_C      = 2'b10;
    localparam logic [1:0] COND_N      = 2'b11;
    function automatic logic [2:0] alu_op(input logic [OPW-1:0] op);
        return op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : op == OP_OR ? ALU_OR : ALU_ADD;
    endfunction
endpackage

// File: rtl/acc_cu_branch_eval.sv
// acc_cu_branch_eval: decides whether a conditional jump is taken from cond and the registered flags
module acc_cu_branch_eval
    import acc_cu_pkg::*;
(
    input  logic [1:0] cond,
    input  logic       cFlag,
    input  logic       zFlag,
    input  logic       nFlag,
    output logic       taken
);
    assign taken = cond == COND_ALWAYS || (cond == COND_Z && zFlag) ||
                   (cond == COND_C && cFlag) || (cond == COND_N && nFlag);
endmodule

// File: rtl/acc_control_unit.sv
// acc_control_unit: multicycle Moore controller sequencing fetch/decode/memory/execute/writeback of the accumulator DataPath
module acc_control_unit
    import acc_cu_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    input  logic [ACW-1:0] acField,
    input  logic [1:0]     cond,
    input  logic           cFlag,
    input  logic           zFlag,
    input  logic           nFlag,
    output logic           pcEn,
    output logic           selAddress,
    output logic           selPCsrc,
    output logic           mr,
    output logic           mw,
    output logic           wordRegEn,
    output logic           LSEn,
    output logic           RSEn,
    output logic           DIEn,
    output logic           selALUsrc,
    output logic           enb,
    output logic           dataRegEn,
    output logic           resultRegEn,
    output logic           CEn,
    output logic           ZEn,
    output logic           NEn,
    output logic [1:0]     selData,
    output logic [ACW-1:0] selAddressAC,
    output logic [2:0]     operation,
    output logic           busy,
    output logic           halted,
    output logic           instrDone
);
    state_t state, state_nx;
    logic taken;
    acc_cu_branch_eval u_branch (.cond(cond), .cFlag(cFlag), .zFlag(zFlag), .nFlag(nFlag), .taken(taken));
    always_ff @(posedge clk)
        state <= reset ? S_IDLE : state_nx;
    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE: state_nx = run ? S_IF : S_IDLE;
            S_IF:   state_nx = S_ID;
            S_ID:   state_nx = opcode == OP_STA ? S_ST : opcode == OP_JCC ? S_BR :
                               opcode == OP_HLT ? S_HALT : S_MEM;
            S_MEM:  state_nx = opcode == OP_LDA ? S_WB : S_EX;
            S_EX:   state_nx = S_WB;
            S_WB, S_ST, S_BR: state_nx = S_IF;
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_IDLE;
        endcase
    end
    // reset gates every control so in-flight writes die in the reset cycle itself
    always_comb begin
        {pcEn, selAddress, selPCsrc, mr, mw, wordRegEn, LSEn, RSEn, DIEn, selALUsrc, enb,
         dataRegEn, resultRegEn, CEn, ZEn, NEn, busy, halted, instrDone} = '0;
        selData = SD_DATA;
        selAddressAC = '0;
        operation = ALU_ADD;
        if (!reset) begin
            busy = state != S_IDLE && state != S_HALT;
            case (state)
                S_IF: {mr, wordRegEn, LSEn, RSEn, pcEn} = '1;
                S_MEM: {mr, selAddress, dataRegEn} = '1;
                S_EX: begin
                    {selALUsrc, resultRegEn, ZEn, NEn} = '1;
                    CEn = opcode == OP_ADD || opcode == OP_SUB;
                    operation = alu_op(opcode);
                    selAddressAC = acField;
                end
                S_WB: begin
                    {enb, DIEn, instrDone} = '1;
                    selData = opcode == OP_LDA ? SD_DATA : SD_ALU;
                    selAddressAC = acField;
                end
                S_ST: begin
                    {mw, selAddress, instrDone} = '1;
                    selAddressAC = acField;
                end
                S_BR: begin
                    {selPCsrc, instrDone} = '1;
                    pcEn = taken;
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_control_unit.sv
// tb_acc_control_unit: table-driven per-cycle output check of acc_control_unit plus halt, reset and latency sequences
module tb_acc_control_unit;
    typedef struct packed {
        logic pcEn, selAddress, selPCsrc, mr, mw, wordRegEn, LSEn, RSEn, DIEn, selALUsrc, enb;
        logic dataRegEn, resultRegEn, CEn, ZEn, NEn;
        logic [1:0] selData, selAddressAC;
        logic [2:0] operation;
        logic busy, halted, instrDone;
    } outs_t;
    typedef struct {
        logic rst, run;
        logic [2:0] opc;
        logic [1:0] ac, cnd;
        logic c, z, n;
        outs_t exp;
    } vec_t;
    logic clk = 0, reset = 1, run = 0, cFlag = 0, zFlag = 0, nFlag = 0;
    logic [2:0] opcode = 0;
    logic [1:0] acField = 0, cond = 0;
    logic pcEn, selAddress, selPCsrc, mr, mw, wordRegEn, LSEn, RSEn, DIEn, selALUsrc, enb;
    logic dataRegEn, resultRegEn, CEn, ZEn, NEn, busy, halted, instrDone;
    logic [1:0] selData, selAddressAC;
    logic [2:0] operation;
    outs_t got;
    vec_t vq[$];
    int checks = 0, errors = 0;
    acc_control_unit dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .acField(acField), .cond(cond),
        .cFlag(cFlag), .zFlag(zFlag), .nFlag(nFlag), .pcEn(pcEn), .selAddress(selAddress),
        .selPCsrc(selPCsrc), .mr(mr), .mw(mw), .wordRegEn(wordRegEn), .LSEn(LSEn), .RSEn(RSEn),
        .DIEn(DIEn), .selALUsrc(selALUsrc), .enb(enb), .dataRegEn(dataRegEn),
        .resultRegEn(resultRegEn), .CEn(CEn), .ZEn(ZEn), .NEn(NEn), .selData(selData),
        .selAddressAC(selAddressAC), .operation(operation), .busy(busy), .halted(halted),
        .instrDone(instrDone)
    );
    assign got = {pcEn, selAddress, selPCsrc, mr, mw, wordRegEn, LSEn, RSEn, DIEn, selALUsrc, enb,
                  dataRegEn, resultRegEn, CEn, ZEn, NEn, selData, selAddressAC, operation,
                  busy, halted, instrDone};
    always #5 clk = ~clk;
    function automatic outs_t o_idle();
        return '0;
    endfunction
    function automatic outs_t o_if();
        outs_t o = '0;
        {o.mr, o.wordRegEn, o.LSEn, o.RSEn, o.pcEn, o.busy} = '1;
        return o;
    endfunction
    function automatic outs_t o_id();
        outs_t o = '0;
        o.busy = 1;
        return o;
    endfunction
    function automatic outs_t o_mem();
        outs_t o = '0;
        {o.mr, o.selAddress, o.dataRegEn, o.busy} = '1;
        return o;
    endfunction
    function automatic outs_t o_ex(logic [1:0] ac, logic [2:0] op, logic cen);
        outs_t o = '0;
        {o.selALUsrc, o.resultRegEn, o.ZEn, o.NEn, o.busy} = '1;
        o.CEn = cen;
        o.operation = op;
        o.selAddressAC = ac;
        return o;
    endfunction
    function automatic outs_t o_wb(logic [1:0] ac, logic [1:0] sd);
        outs_t o = '0;
        {o.enb, o.DIEn, o.instrDone, o.busy} = '1;
        o.selAddressAC = ac;
        o.selData = sd;
        return o;
    endfunction
    function automatic outs_t o_st(logic [1:0] ac);
        outs_t o = '0;
        {o.mw, o.selAddress, o.instrDone, o.busy} = '1;
        o.selAddressAC = ac;
        return o;
    endfunction
    function automatic outs_t o_br(logic pc);
        outs_t o = '0;
        {o.selPCsrc, o.instrDone, o.busy} = '1;
        o.pcEn = pc;
        return o;
    endfunction
    function automatic outs_t o_halt();
        outs_t o = '0;
        o.halted = 1;
        return o;
    endfunction
    function automatic void add(logic rst, logic rn, logic [2:0] opc, logic [1:0] ac, logic [1:0] cnd,
                                logic c, logic z, logic n, outs_t exp);
        vec_t v;
        v.rst = rst; v.run = rn; v.opc = opc; v.ac = ac; v.cnd = cnd;
        v.c = c; v.z = z; v.n = n; v.exp = exp;
        vq.push_back(v);
    endfunction
    function automatic void ins_lda(logic [1:0] ac);
        add(0, 0, 3'b000, ac, 0, 0, 0, 0, o_if());
        add(0, 0, 3'b000, ac, 0, 0, 0, 0, o_id());
        add(0, 0, 3'b000, ac, 0, 0, 0, 0, o_mem());
        add(0, 0, 3'b000, ac, 0, 0, 0, 0, o_wb(ac, 2'b00));
    endfunction
    function automatic void ins_alu(logic [2:0] opc, logic [1:0] ac, logic [2:0] aop, logic cen);
        add(0, 0, opc, ac, 0, 0, 0, 0, o_if());
        add(0, 0, opc, ac, 0, 0, 0, 0, o_id());
        add(0, 0, opc, ac, 0, 0, 0, 0, o_mem());
        add(0, 0, opc, ac, 0, 0, 0, 0, o_ex(ac, aop, cen));
        add(0, 0, opc, ac, 0, 0, 0, 0, o_wb(ac, 2'b01));
    endfunction
    function automatic void ins_jcc(logic [1:0] cnd, logic c, logic z, logic n, logic tk);
        add(0, 0, 3'b110, 1, cnd, c, z, n, o_if());
        add(0, 0, 3'b110, 1, cnd, c, z, n, o_id());
        add(0, 0, 3'b110, 1, cnd, c, z, n, o_br(tk));
    endfunction
    task automatic check(string nm, outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask
    initial begin
        int n;
        add(1, 0, 0, 0, 0, 0, 0, 0, o_idle());
        add(0, 0, 0, 0, 0, 0, 0, 0, o_idle());
        add(0, 1, 0, 1, 0, 0, 0, 0, o_idle());
        ins_lda(1);
        ins_alu(3'b011, 2, 3'b001, 1);
        ins_alu(3'b100, 3, 3'b010, 0);
        ins_alu(3'b010, 1, 3'b000, 1);
        ins_alu(3'b101, 0, 3'b011, 0);
        ins_jcc(2'b01, 1, 0, 1, 0);
        ins_jcc(2'b01, 0, 1, 0, 1);
        ins_jcc(2'b00, 0, 0, 0, 1);
        ins_jcc(2'b10, 0, 1, 1, 0);
        ins_jcc(2'b11, 0, 0, 1, 1);
        add(0, 0, 3'b001, 2, 0, 0, 0, 0, o_if());
        add(0, 0, 3'b001, 2, 0, 0, 0, 0, o_id());
        add(0, 0, 3'b001, 2, 0, 0, 0, 0, o_st(2));
        add(0, 0, 3'b111, 0, 0, 0, 0, 0, o_if());
        add(0, 0, 3'b111, 0, 0, 0, 0, 0, o_id());
        add(0, 1, 3'b111, 0, 0, 0, 0, 0, o_halt());
        foreach (vq[i]) begin
            @(negedge clk);
            reset = vq[i].rst; run = vq[i].run; opcode = vq[i].opc; acField = vq[i].ac;
            cond = vq[i].cnd; cFlag = vq[i].c; zFlag = vq[i].z; nFlag = vq[i].n;
            #1 check($sformatf("vec%0d", i), vq[i].exp);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            run = i[0];
            opcode = i[2:0];
            #1 check($sformatf("halt_hold%0d", i), o_halt());
        end
        @(negedge clk); reset = 1; run = 0;
        #1 check("rst_from_halt", o_idle());
        @(negedge clk); reset = 0; run = 1; opcode = 3'b010; acField = 1;
        #1 check("idle_run", o_idle());
        @(negedge clk); run = 0;
        #1 check("add_if", o_if());
        @(negedge clk);
        #1 check("add_id", o_id());
        @(negedge clk);
        #1 check("add_mem", o_mem());
        @(negedge clk);
        #1 check("add_ex", o_ex(1, 3'b000, 1));
        @(negedge clk); reset = 1;
        #1 check("rst_in_ex", o_idle());
        @(negedge clk); reset = 0;
        #1 check("idle_after_rst", o_idle());
        @(negedge clk);
        #1 check("idle_stays", o_idle());
        @(negedge clk); run = 1; opcode = 3'b111;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            run = 0;
            n++;
            #1 if (halted) break;
        end
        checks++;
        if (n != 3 || !halted) begin
            errors++;
            $display("FAIL hlt_latency: cycles %0d halted %0b expected cycles 3 halted 1", n, halted);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/acc_control_unit.md
Name: acc_control_unit

Overview:
- Multicycle Moore controller that sequences the accumulator DataPath: fetch, decode, memory access, ALU execute and writeback.
- Drives every DataPath control input and receives the decoded instruction fields and C/Z/N flags back.
- Sits beside DataPath inside the CPU top; one instruction is in flight at a time.

Parameters:
- OPW, 3, opcode width (fixed ISA, for documentation and package use).
- ACW, 2, accumulator-select field width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  start execution from IDLE.
- opcode  in  3  instruction opcode from the word register.
- acField  in  2  accumulator index field from the instruction.
- cond  in  2  branch condition field: 00 always, 01 Z, 10 C, 11 N.
- cFlag, zFlag, nFlag  in  1 each  DataPath flag registers.
- pcEn, selAddress, selPCsrc, mr, mw, wordRegEn, LSEn, RSEn, DIEn, selALUsrc, enb, dataRegEn, resultRegEn, CEn, ZEn, NEn  out  1 each  DataPath controls.
- selData  out  2  accumulator write source: 00 = data register, 01 = ALU result.
- selAddressAC  out  2  accumulator index.
- operation  out  3  ALU operation code.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- instrDone  out  1  one-cycle pulse in the last state of each instruction.

Behaviour:
- Reset is synchronous, active-high:
  - state goes to IDLE.
  - All outputs are 0, including busy, halted and instrDone.
- Outputs are purely state-decoded (Moore), except the listed dependencies on opcode, cond and the flags within a state.
- Any output not listed for a state is 0.
- ISA: 000 LDA, 001 STA, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 JCC, 111 HLT.
- States and transitions:
  - IDLE: go to IF when run=1, else stay.
  - IF:
    - Outputs: mr=1, selAddress=0, wordRegEn=1, LSEn=1, RSEn=1, pcEn=1, selPCsrc=0 (PC+1).
    - Next state: ID.
  - ID: no controls; branch on opcode.
    - LDA/ADD/SUB/AND/OR go to MEM.
    - STA goes to ST.
    - JCC goes to BR.
    - HLT goes to HALT.
  - MEM:
    - Outputs: mr=1, selAddress=1, dataRegEn=1.
    - Next state: WB for LDA, else EX.
  - EX:
    - Outputs: selALUsrc=1, selAddressAC=acField, resultRegEn=1, operation = ADD 000 / SUB 001 / AND 010 / OR 011.
    - ADD/SUB: CEn=ZEn=NEn=1. AND/OR: ZEn=NEn=1, CEn=0.
    - Next state: WB.
  - WB:
    - Outputs: enb=1, DIEn=1, selAddressAC=acField, instrDone=1.
    - selData=00 for LDA, 01 otherwise.
    - Next state: IF.
  - ST:
    - Outputs: mw=1, selAddress=1, selAddressAC=acField, instrDone=1.
    - Next state: IF.
  - BR:
    - taken = cond 00, or the selected flag is 1.
    - pcEn=taken, selPCsrc=1, instrDone=1.
    - Next state: IF.
  - HALT: halted=1. Stay until reset; run is ignored.
- Instruction cycle counts: LDA 4, STA 3, ALU ops 5, JCC 3, HLT 2 to reach HALT.
- Operand sampling:
  - opcode, acField and cond are sampled only in ID/MEM/EX/WB/ST/BR.
  - The word register must be stable from ID onward; wordRegEn is high only in IF.
- run is level-sensitive in IDLE only. Deasserting run mid-instruction has no effect; execution never returns to IDLE without reset.
- reset asserted in any state: state=IDLE on the next edge. In-flight writes are abandoned; mw/enb are 0 from that cycle on.
- Flags are sampled in BR from the registered DataPath flags, so they reflect the last EX.
- Illegal or unreachable state encodings recover to IDLE.

Decomposition:
- Package acc_cu_pkg holds:
  - state enum: IDLE, IF, ID, MEM, EX, WB, ST, BR, HALT.
  - opcode constants.
  - ALU operation constants.
  - selData and cond encodings.
- One sub-module, acc_cu_branch_eval: combinational cond/flag check producing taken.
- The FSM next-state and output decoder stay in acc_control_unit.

Test Plan:
- Reset, then run=1, opcode=000: states IDLE→IF→ID→MEM→WB.
  - IF: mr=1, pcEn=1. MEM: dataRegEn=1.
  - WB: selData=00, enb=1, instrDone=1.
  - Next cycle is IF.
- opcode=011, acField=2: EX has operation=001, CEn=ZEn=NEn=1, selAddressAC=2. WB has selData=01. 5 cycles total.
- opcode=100 (AND): EX has operation=010, CEn=0, ZEn=NEn=1.
- opcode=110:
  - cond=01, zFlag=0: BR has pcEn=0.
  - cond=01, zFlag=1: BR has pcEn=1, selPCsrc=1.
  - cond=00: pcEn=1 regardless of flags.
- opcode=001: ST has mw=1, selAddress=1, mr=0. 3 cycles; instrDone pulses exactly once.
- opcode=111 reaches HALT with halted=1, busy=0, and stays there for 20 cycles with run toggling. Reset asserted during EX gives IDLE next cycle with all outputs 0.
